// File: rtl/cheri_pkg.sv
// Shared types and parameter checks for the CHERIoT data-memory responder.
package cheri_pkg;

    localparam int unsigned CapWordW = 33;

    typedef struct packed {
        logic                err;
        logic [CapWordW-1:0] rdata;
    } mem_resp_t;

    function automatic bit resp_latency_legal(input int unsigned lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

endpackage

// File: rtl/cheri_mem_resp_pipe.sv
// Fixed-depth response shift pipe; only the valid bits are reset so that
// in-flight responses vanish on reset while the payload path stays plain flops.
module cheri_mem_resp_pipe #(
    parameter int unsigned Depth    = 1,
    parameter int unsigned PayloadW = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [PayloadW-1:0] payload_i,
    output logic                valid_o,
    output logic [PayloadW-1:0] payload_o
);

    logic [Depth-1:0]    vld_q;
    logic [PayloadW-1:0] pay_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < Depth; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        pay_q[0] <= payload_i;
        for (int i = 1; i < Depth; i++) begin
            pay_q[i] <= pay_q[i-1];
        end
    end

    assign valid_o   = vld_q[Depth-1];
    assign payload_o = pay_q[Depth-1];

endmodule

// File: rtl/cheri_data_mem_resp.sv
// Data-side memory responder for the CHERIoT core: tagged word memory with
// combinational grant, bench-controlled stalls and fixed-latency in-order responses.
module cheri_data_mem_resp
    import cheri_pkg::*;
#(
    parameter int unsigned DataWidth   = 33,
    parameter logic [31:0] MemBase     = 32'h8000_0000,
    parameter int unsigned MemAddrW    = 12,
    parameter int unsigned RespLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 data_req_i,
    input  logic                 data_is_cap_i,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    input  logic                 gnt_stall_i,
    output logic                 data_gnt_o,
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o
);

    localparam int unsigned MemWords = 2 ** MemAddrW;
    localparam int unsigned RespW    = $bits(mem_resp_t);

    if (!resp_latency_legal(RespLatency) || (DataWidth != CapWordW)) begin : g_param_check
        $error("cheri_data_mem_resp: RespLatency must be 1..4 and DataWidth must be 33");
    end

    logic [DataWidth-1:0] mem_q [MemWords];

    logic [31:0]          off;
    logic                 in_range;
    logic [MemAddrW-1:0]  idx;
    logic [DataWidth-1:0] cur_word;
    logic [DataWidth-1:0] wr_word;
    logic                 wr_en;
    mem_resp_t            resp_d;
    mem_resp_t            resp_q;
    logic [RespW-1:0]     pipe_pay;
    logic                 pipe_vld;
    logic                 unused_addr_bits;

    assign data_gnt_o = data_req_i & ~gnt_stall_i;

    // Byte offset from the memory base; wrap-around below the base lands far out of range.
    assign off              = data_addr_i - MemBase;
    assign in_range         = ({2'b00, off[31:2]} < 32'(MemWords));
    assign idx              = off[MemAddrW+1:2];
    assign cur_word         = mem_q[idx];
    assign unused_addr_bits = ^off[1:0];

    always_comb begin
        wr_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (data_be_i[i]) begin
                wr_word[8*i +: 8] = data_wdata_i[8*i +: 8];
            end
        end
        // Any non-capability store to the word invalidates its tag.
        wr_word[DataWidth-1] = data_is_cap_i & data_wdata_i[DataWidth-1];
    end

    assign wr_en = data_gnt_o & data_we_i & in_range & (|data_be_i);

    // A write whose edge coincides with reset assertion is dropped.
    always_ff @(posedge clk_i) begin
        if (wr_en && rst_ni) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_comb begin
        resp_d = '0;
        if (!in_range) begin
            resp_d.err = 1'b1;
        end else if (!data_we_i) begin
            resp_d.rdata[31:0]       = cur_word[31:0];
            resp_d.rdata[CapWordW-1] = data_is_cap_i & cur_word[DataWidth-1];
        end
    end

    cheri_mem_resp_pipe #(
        .Depth    (RespLatency),
        .PayloadW (RespW)
    ) u_pipe (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (data_gnt_o),
        .payload_i (resp_d),
        .valid_o   (pipe_vld),
        .payload_o (pipe_pay)
    );

    assign resp_q        = pipe_pay;
    assign data_rvalid_o = pipe_vld;
    assign data_err_o    = pipe_vld & resp_q.err;
    assign data_rdata_o  = pipe_vld ? resp_q.rdata : '0;

endmodule

// File: tb/tb_cheri_data_mem_resp.sv
// Directed bench: two responders (latency 1 and 3) share one stimulus stream.
module tb_cheri_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, cap, we, stall;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic        g1, rv1, er1, g3, rv3, er3;
    logic [32:0] rd1, rd3;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    cheri_data_mem_resp #(.RespLatency(1)) u_lat1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_is_cap_i(cap),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .gnt_stall_i(stall), .data_gnt_o(g1), .data_rvalid_o(rv1),
        .data_rdata_o(rd1), .data_err_o(er1)
    );

    cheri_data_mem_resp #(.RespLatency(3)) u_lat3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_is_cap_i(cap),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .gnt_stall_i(stall), .data_gnt_o(g3), .data_rvalid_o(rv3),
        .data_rdata_o(rd3), .data_err_o(er3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rsp1(input string tag, input logic v, input logic e, input logic [32:0] d);
        check({tag, ".rvalid1"}, rv1, v);
        check({tag, ".err1"}, er1, e);
        check({tag, ".rdata1"}, rd1, d);
    endtask

    task automatic rsp3(input string tag, input logic v, input logic e, input logic [32:0] d);
        check({tag, ".rvalid3"}, rv3, v);
        check({tag, ".err3"}, er3, e);
        check({tag, ".rdata3"}, rd3, d);
    endtask

    task automatic drive(input logic w, input logic c, input logic [3:0] b,
                         input logic [31:0] a, input logic [32:0] d);
        req = 1'b1; we = w; cap = c; be = b; addr = a; wdata = d;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; cap = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rsp1("reset", 1'b0, 1'b0, 33'h0);
        rsp3("reset", 1'b0, 1'b0, 33'h0);
        req = 1'b1;
        #1;
        check("gnt_in_reset1", g1, 1'b1);
        check("gnt_in_reset3", g3, 1'b1);
        stall = 1'b1;
        #1;
        check("gnt_stall_in_reset", g1, 1'b0);
        stall = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read, write followed directly by read of the same word
        drive(1'b1, 1'b1, 4'hF, 32'h8000_0010, 33'h1_DEAD_BEEF);
        #1;
        check("gnt_wr", g1, 1'b1);
        @(negedge clk);
        rsp1("wr_resp", 1'b1, 1'b0, 33'h0);
        drive(1'b0, 1'b1, 4'hF, 32'h8000_0010, 33'h0);
        @(negedge clk);
        rsp1("cap_rd", 1'b1, 1'b0, 33'h1_DEAD_BEEF);
        drive(1'b1, 1'b0, 4'b0010, 32'h8000_0010, 33'h1_0000_5500);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 32'h8000_0010, 33'h0);
        @(negedge clk);
        rsp1("partial", 1'b1, 1'b0, 33'h0_DEAD_55EF);
        rsp3("cap_rd_lat3", 1'b1, 1'b0, 33'h1_DEAD_BEEF);

        // Tag visible only on capability reads; be==0 leaves word intact
        drive(1'b1, 1'b1, 4'hF, 32'h8000_0020, 33'h1_1234_5678);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'hF, 32'h8000_0020, 33'h0);
        @(negedge clk);
        rsp1("noncap_rd", 1'b1, 1'b0, 33'h0_1234_5678);
        drive(1'b1, 1'b0, 4'h0, 32'h8000_0020, 33'h0_FFFF_FFFF);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 32'h8000_0020, 33'h0);
        @(negedge clk);
        rsp1("be0_rd", 1'b1, 1'b0, 33'h1_1234_5678);

        // Out-of-range accesses, then confirm the aliased edge words are intact
        drive(1'b1, 1'b1, 4'hF, 32'h8000_3FFC, 33'h1_CAFE_F00D);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'h8000_0000, 33'h0_0BAD_C0DE);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'hF, 32'h7FFF_FFFC, 33'h1_FFFF_FFFF);
        @(negedge clk);
        rsp1("oor_wr_low", 1'b1, 1'b1, 33'h0);
        drive(1'b1, 1'b0, 4'hF, 32'h8000_4000, 33'h0_AAAA_AAAA);
        @(negedge clk);
        rsp1("oor_wr_high", 1'b1, 1'b1, 33'h0);
        drive(1'b0, 1'b1, 4'hF, 32'h9000_0000, 33'h0);
        @(negedge clk);
        rsp1("oor_rd", 1'b1, 1'b1, 33'h0);
        drive(1'b0, 1'b1, 4'hF, 32'h8000_3FFC, 33'h0);
        @(negedge clk);
        rsp1("last_word", 1'b1, 1'b0, 33'h1_CAFE_F00D);
        drive(1'b0, 1'b1, 4'hF, 32'h8000_0000, 33'h0);
        @(negedge clk);
        rsp1("word0", 1'b1, 1'b0, 33'h0_0BAD_C0DE);
        drive(1'b0, 1'b1, 4'hF, 32'h8000_0010, 33'h0);
        @(negedge clk);
        rsp1("word4", 1'b1, 1'b0, 33'h0_DEAD_55EF);
        idle();
        @(negedge clk);
        rsp1("idle", 1'b0, 1'b0, 33'h0);

        // Pipelined order: words hold 1..4, four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 4'hF, 32'(32'h8000_0100 + 4 * i), 33'(i + 1));
            @(negedge clk);
        end
        idle();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rsp1($sformatf("pipe_%0d", i), (i >= 1 && i <= 4), 1'b0,
                 (i >= 1 && i <= 4) ? 33'(i) : 33'h0);
            rsp3($sformatf("pipe_%0d", i), (i >= 3 && i <= 6), 1'b0,
                 (i >= 3 && i <= 6) ? 33'(i - 2) : 33'h0);
            if (i < 4) drive(1'b0, 1'b0, 4'hF, 32'(32'h8000_0100 + 4 * i), 33'h0);
            else idle();
            @(negedge clk);
        end

        // Grant stall: held request, no grant and no response for 5 cycles
        stall = 1'b1;
        drive(1'b0, 1'b0, 4'hF, 32'h8000_0100, 33'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall_gnt1_%0d", i), g1, 1'b0);
            check($sformatf("stall_gnt3_%0d", i), g3, 1'b0);
            @(negedge clk);
            check($sformatf("stall_rv1_%0d", i), rv1, 1'b0);
            check($sformatf("stall_rv3_%0d", i), rv3, 1'b0);
        end
        stall = 1'b0;
        #1;
        check("stall_release_gnt", g1, 1'b1);
        @(negedge clk);
        rsp1("stall_rel", 1'b1, 1'b0, 33'h1);
        idle();
        @(negedge clk);
        rsp1("stall_rel_after", 1'b0, 1'b0, 33'h0);
        @(negedge clk);
        rsp3("stall_rel", 1'b1, 1'b0, 33'h1);

        // Reset mid-operation with a write granted on the reset edge
        drive(1'b0, 1'b0, 4'hF, 32'h8000_0104, 33'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'hF, 32'h8000_0108, 33'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 4'hF, 32'h8000_0104, 33'h0_0000_0077);
        rst_n = 1'b0;
        #1;
        rsp1("rst_assert", 1'b0, 1'b0, 33'h0);
        rsp3("rst_assert", 1'b0, 1'b0, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_rv1_%0d", i), rv1, 1'b0);
            check($sformatf("post_rst_rv3_%0d", i), rv3, 1'b0);
        end
        drive(1'b0, 1'b0, 4'hF, 32'h8000_0104, 33'h0);
        @(negedge clk);
        rsp1("retain", 1'b1, 1'b0, 33'h0_0000_0002);
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cheri_data_mem_resp.md
# cheri_data_mem_resp

Responder for the core's CHERIoT data memory port: it answers `data_req`/`data_gnt`/`data_rvalid` transactions from the initiator side of `ibex_top`. It holds a word-addressed 33-bit memory in which bit 32 is the capability tag, and returns in-order responses after a fixed latency. It provides bench-controlled grant stalls and an out-of-range error. It sits beside the core in simulation and FPGA top levels, as the data-side counterpart of the core's load/store unit.

## Interface
- `DataWidth`, 33: data bus width; bit 32 is the tag.
- `MemBase`, 32'h8000_0000: byte address of word 0.
- `MemAddrW`, 12: log2 of the word count (default 4096 words, 16 KiB).
- `RespLatency`, 1: cycles from grant to `data_rvalid_o`; legal range 1..4.

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `data_req_i` in 1: request valid.
- `data_is_cap_i` in 1: word belongs to a capability access; the tag is significant.
- `data_we_i` in 1: write when 1, read when 0.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address, word aligned.
- `data_wdata_i` in DataWidth: write data.
- `gnt_stall_i` in 1: bench-driven; when 1, the grant is withheld.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_rvalid_o` out 1: response valid, one cycle per granted request.
- `data_rdata_o` out DataWidth: read data.
- `data_err_o` out 1: response error, qualified by `data_rvalid_o`.

## Operation
- **Grant.** `data_gnt_o = data_req_i & ~gnt_stall_i`, purely combinational. At most one transaction is accepted per cycle. Request fields are sampled only in the grant cycle.
- **Address decode.** `off = data_addr_i - MemBase`. The access is in range iff `off[31:2] < 2**MemAddrW`. Word index is `off[MemAddrW+1:2]`. `data_addr_i[1:0]` is ignored.
- **Write, in range.** The memory updates at the clock edge ending the grant cycle.
  - For each `be[i]`, byte i of bits 31:0 is taken from wdata.
  - Tag (bit 32) is written as `wdata[32]` when `is_cap=1`; otherwise it is cleared, provided `be != 0`.
  - `be == 0` leaves the word and its tag unchanged.
- **Read, in range.** The word is read at the grant cycle, so it sees all earlier granted writes.
  - Response `rdata[31:0]` is the stored bits.
  - `rdata[32]` is the stored tag when `is_cap=1`, otherwise 0.
- **Out of range.** The response has `err=1` and `rdata=0`. Writes are suppressed.
- **Response path.** `{valid, err, rdata}` enters a RespLatency-deep shift pipe at grant and emerges exactly RespLatency cycles later.
  - Responses are in order.
  - The initiator has no backpressure, so the pipe never stalls.
  - Outstanding count is implicitly bounded by RespLatency.
- **Idle output.** When `data_rvalid_o=0`, `data_rdata_o` and `data_err_o` are driven to 0.

## Timing
- **Reset values.**
  - `data_rvalid_o=0`, `data_err_o=0`, `data_rdata_o=0`, all pipe valid bits 0.
  - `data_gnt_o` follows its combinational equation, so it reflects `data_req_i & ~gnt_stall_i` even while in reset.
  - Memory contents are not reset.
- **Latency.** A grant at cycle N gives `data_rvalid_o=1` at cycle N+RespLatency.
- **Throughput.** Back-to-back grants on consecutive cycles give back-to-back rvalid pulses.
- **Stall.** While `gnt_stall_i=1` with req held, no grant is issued and no state changes. The grant occurs in the first cycle the stall drops.
- **Simultaneous events.** A response emerging in the same cycle as a new grant is allowed; the two are independent.
- **Write-then-read.** A write granted at N followed by a read granted at N+1 to the same word returns the new data.
- **Reset mid-operation.** All in-flight responses are discarded, and no rvalid is produced for them after reset releases. A write whose grant edge coincides with reset assertion is dropped.

## Structure
- `mem_resp_t {logic err; logic [DataWidth-1:0] rdata;}` and the `RespLatency` legality check live in `cheri_pkg`.
- The latency pipe is a natural sub-module, `cheri_mem_resp_pipe`: depth parameter, valid and payload shift registers, asynchronous reset on the valid bits only.
- The memory array is a plain register array, without reset, in the top module.

## Test plan
- **Basic write/read.** Write 0xDEADBEEF, `is_cap=1`, `wdata[32]=1`, `be=4'hF` at 0x8000_0010; then a cap read of the same address. Expect `rdata=33'h1_DEADBEEF`, `err=0`, one cycle after grant with RespLatency=1.
- **Tag clear on partial write.** After the previous step, a non-cap write with `be=4'b0010`, `wdata=0x0000_5500`; then a cap read. Expect `33'h0_DEAD55EF`.
- **Out-of-range write.** Write to 0x7FFF_FFFC. Expect `err=1`, `rdata=0`. A later read of every in-range word is unchanged.
- **Pipelined order.** With RespLatency=3, four back-to-back reads of words holding 1,2,3,4. Expect rvalid on cycles N+3..N+6, returning 1,2,3,4 in order.
- **Grant stall.** Hold req with `gnt_stall_i=1` for 5 cycles. Expect no `data_gnt_o` and no rvalid. Drop the stall: grant in the same cycle, rvalid RespLatency cycles later.
- **Reset mid-operation.** With RespLatency=3, grant two reads, then assert `rst_ni` for 1 cycle. Expect no rvalid after release; memory contents are retained.
